// File: rtl/datapath_pkg.sv
// Constants shared by the multicycle datapath blocks (PC register, PC adder,
// memory address mux and branch unit).
package datapath_pkg;

  localparam int unsigned          PC_WIDTH       = 16;
  localparam logic [PC_WIDTH-1:0]  PC_RESET_VALUE = 16'h0000;

endpackage : datapath_pkg

// File: rtl/pc_write_ctrl.sv
// PC load-enable decode: unconditional write, or a branch write qualified by
// the ALU zero flag (beq takes on zero, bne takes on non-zero).
module pc_write_ctrl (
  input  logic PCWrite,
  input  logic PCWriteBeq,
  input  logic PCWriteBne,
  input  logic Is_Zero,
  output logic en
);

  // With both branch strobes up, exactly one term is true, so the PC loads.
  assign en = PCWrite | (PCWriteBeq & Is_Zero) | (PCWriteBne & ~Is_Zero);

endmodule : pc_write_ctrl

// File: rtl/pc_register.sv
// Program-counter state register: holds the current instruction address and
// loads DataIn on a qualifying write; reset wins over any pending load.
module pc_register
  import datapath_pkg::*;
#(
  parameter int unsigned           WIDTH       = PC_WIDTH,
  parameter logic [WIDTH-1:0]      RESET_VALUE = WIDTH'(PC_RESET_VALUE)
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [WIDTH-1:0] DataIn,
  input  logic             PCWrite,
  input  logic             PCWriteBeq,
  input  logic             PCWriteBne,
  input  logic             Is_Zero,
  output logic [WIDTH-1:0] DataOut
);

  logic             en;
  logic [WIDTH-1:0] pc_reg;

  pc_write_ctrl u_pc_write_ctrl (
    .PCWrite    (PCWrite),
    .PCWriteBeq (PCWriteBeq),
    .PCWriteBne (PCWriteBne),
    .Is_Zero    (Is_Zero),
    .en         (en)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      pc_reg <= RESET_VALUE;
    end else if (en) begin
      pc_reg <= DataIn;
    end
  end

  // Straight from the flops so the instruction-memory address is glitch-free.
  assign DataOut = pc_reg;

endmodule : pc_register

// File: tb/tb_pc_register.sv
// Directed bench for pc_register: a per-cycle model comparison plus literal
// expectations for each scenario.
module tb_pc_register;

  localparam int unsigned W = 16;

  logic         CLK = 1'b0;
  logic         Reset = 1'b1;
  logic [W-1:0] DataIn = '0;
  logic         PCWrite = 1'b0;
  logic         PCWriteBeq = 1'b0;
  logic         PCWriteBne = 1'b0;
  logic         Is_Zero = 1'b0;
  logic [W-1:0] DataOut;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] model_pc;
  logic         model_valid = 1'b0;

  pc_register #(.WIDTH(W), .RESET_VALUE(16'h0000)) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .DataIn     (DataIn),
    .PCWrite    (PCWrite),
    .PCWriteBeq (PCWriteBeq),
    .PCWriteBne (PCWriteBne),
    .Is_Zero    (Is_Zero),
    .DataOut    (DataOut)
  );

  always #5 CLK = ~CLK;

  // Model: the PC takes DataIn when a write is requested or the selected
  // branch condition holds; reset always returns it to zero.
  always @(posedge CLK) begin
    bit taken;
    taken = (PCWrite == 1'b1) || (Is_Zero ? (PCWriteBeq == 1'b1) : (PCWriteBne == 1'b1));
    if (Reset) begin
      model_pc    <= 16'h0000;
      model_valid <= 1'b1;
    end else if (taken) begin
      model_pc    <= DataIn;
      model_valid <= 1'b1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    if (model_valid) begin
      checks++;
      if (DataOut !== model_pc) begin
        errors++;
        $display("FAIL model_cmp t=%0t: DataOut=%h expected=%h", $time, DataOut, model_pc);
      end
    end
  end

  task automatic check_lit(input string name, input logic [W-1:0] exp);
    checks++;
    if (DataOut !== exp) begin
      errors++;
      $display("FAIL %s: DataOut=%h expected=%h", name, DataOut, exp);
    end else begin
      $display("ok   %s: DataOut=%h", name, DataOut);
    end
  endtask

  // Present inputs on the falling edge, then return just after the next rise.
  task automatic step(input logic rst, input logic wr, input logic beq,
                      input logic bne, input logic z, input logic [W-1:0] din);
    @(negedge CLK);
    Reset = rst; PCWrite = wr; PCWriteBeq = beq; PCWriteBne = bne;
    Is_Zero = z; DataIn = din;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // Reset, then basic writes
    step(1, 0, 0, 0, 0, 16'h0000);  check_lit("reset",        16'h0000);
    step(0, 1, 0, 0, 0, 16'h0001);  check_lit("write_1",      16'h0001);
    step(0, 1, 0, 0, 0, 16'h0002);  check_lit("write_2",      16'h0002);
    // beq
    step(0, 0, 1, 0, 0, 16'h0003);  check_lit("beq_not_taken", 16'h0002);
    step(0, 0, 1, 0, 1, 16'h0004);  check_lit("beq_taken",    16'h0004);
    // bne
    step(0, 0, 0, 1, 1, 16'h0005);  check_lit("bne_not_taken", 16'h0004);
    step(0, 0, 0, 1, 0, 16'h0006);  check_lit("bne_taken",    16'h0006);
    // Unconditional write ignores the zero flag
    step(0, 1, 0, 0, 1, 16'h0007);  check_lit("write_prio",   16'h0007);
    // Idle hold while DataIn toggles
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, i[0], (i % 2 == 0) ? 16'h1234 : 16'hFFFF);
      check_lit("idle_hold", 16'h0007);
    end
    // Both branch strobes: one of them is always taken
    step(0, 0, 1, 1, 0, 16'h00A5);  check_lit("both_br_z0",   16'h00A5);
    step(0, 0, 1, 1, 1, 16'h5A00);  check_lit("both_br_z1",   16'h5A00);
    // Reset beats a pending taken branch; the load is dropped, not deferred
    step(1, 0, 1, 0, 1, 16'h0BAD);  check_lit("reset_vs_beq", 16'h0000);
    step(0, 0, 0, 0, 1, 16'h0BAD);  check_lit("no_deferred",  16'h0000);
    // Reset priority over write, then one-cycle latency of the next write
    step(1, 1, 0, 0, 0, 16'hFFFF);  check_lit("reset_vs_write", 16'h0000);
    @(negedge CLK);
    Reset = 1'b0; PCWrite = 1'b1; DataIn = 16'hFFFF;
    #2;                              check_lit("latency_pre",  16'h0000);
    @(posedge CLK); #1;              check_lit("latency_post", 16'hFFFF);
    step(0, 0, 0, 0, 0, 16'h0000);  check_lit("full_width_hold", 16'hFFFF);
    @(negedge CLK);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_pc_register
